// File: rtl/kb_queue_ctrl.sv
// kb_queue_ctrl: sequencer and arbiter in front of the keyboard char_queue.
// The PS/2 decoder pushes entries through a one-deep hold register. The CPU
// pops entries through a single pending-read flag. Each queue access is
// shaped into a one-cycle write/read strobe followed by a wait cycle. When
// both sides are waiting, the side that was not served last is granted.
//
// Ports
//   clk, rst_n        system clock, async active-low reset
//   dec_vld_i         decoder event pulse, with dec_entry_i / dec_make_i
//   cpu_rd_req_i      CPU pop request pulse
//   cpu_ovf_clr_i     clears the overflow flag and the drop counter
//   cpu_rd_vld_o      response strobe, with cpu_rd_data_o / cpu_rd_empty_o
//   ovf_o, ovf_cnt_o  sticky drop flag and saturating drop count
//   pending_o         hold register occupied
//   q_write_o, q_read_o, q_entry_o, q_make_o   towards char_queue
//   q_entry_i, q_empty_i, q_full_i             from char_queue
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | arbitrate between the hold register and the pending read
// WR       | q_write_o strobe; entry comes from the hold register
// WR_WAIT  | queue stores the entry; the hold register is freed at the end
// RD       | q_read_o strobe
// RD_WAIT  | queue presents the entry; it is captured at the end
// RESP     | cpu_rd_vld_o strobe with the captured data / empty flag
module kb_queue_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  dec_vld_i,
  input  logic [17:0]           dec_entry_i,
  input  logic                  dec_make_i,
  input  logic                  cpu_rd_req_i,
  input  logic                  cpu_ovf_clr_i,
  output logic                  cpu_rd_vld_o,
  output logic [DATA_WIDTH-1:0] cpu_rd_data_o,
  output logic                  cpu_rd_empty_o,
  output logic                  ovf_o,
  output logic [CNT_W-1:0]      ovf_cnt_o,
  output logic                  pending_o,
  output logic                  q_write_o,
  output logic                  q_read_o,
  output logic [17:0]           q_entry_o,
  output logic                  q_make_o,
  input  logic [DATA_WIDTH-1:0] q_entry_i,
  input  logic                  q_empty_i,
  input  logic                  q_full_i
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR      = 3'd1,
    ST_WR_WAIT = 3'd2,
    ST_RD      = 3'd3,
    ST_RD_WAIT = 3'd4,
    ST_RESP    = 3'd5
  } state_t;

  // The decoder emits this entry for events that carry no character.
  localparam logic [17:0] FILTER_ENTRY = 18'h3FFFF;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_hold_vld;
  logic [17:0]           r_hold_entry;
  logic                  r_hold_make;
  logic                  r_rd_pend;
  logic                  r_last_wr;
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic                  r_rd_empty;
  logic                  r_ovf;
  logic [CNT_W-1:0]      r_ovf_cnt;
  logic                  r_q_write;
  logic                  r_q_read;
  logic                  r_cpu_rd_vld;

  logic w_wr_cand;
  logic w_rd_cand;
  logic w_grant_wr;
  logic w_grant_rd;
  logic w_evt;
  logic w_hold_release;
  logic w_hold_load;
  logic w_drop;
  logic w_rd_inflight;
  logic w_q_write_nxt;
  logic w_q_read_nxt;
  logic w_cpu_rd_vld_nxt;

  assign w_wr_cand  = r_hold_vld & ~q_full_i;
  assign w_rd_cand  = r_rd_pend;
  // Under contention the side not served last wins.
  assign w_grant_wr = w_wr_cand & (~w_rd_cand | ~r_last_wr);
  assign w_grant_rd = w_rd_cand & ~w_grant_wr;

  assign w_evt          = dec_vld_i & (dec_entry_i != FILTER_ENTRY);
  // The hold register may be refilled on the same edge that frees it.
  assign w_hold_release = (r_state == ST_WR_WAIT);
  assign w_hold_load    = w_evt & (~r_hold_vld | w_hold_release);
  assign w_drop         = w_evt & ~w_hold_load;

  assign w_rd_inflight = (r_state == ST_RD) | (r_state == ST_RD_WAIT) |
                         (r_state == ST_RESP);

  // State register, including the registered strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_q_write    <= 1'b0;
      r_q_read     <= 1'b0;
      r_cpu_rd_vld <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_q_write    <= w_q_write_nxt;
      r_q_read     <= w_q_read_nxt;
      r_cpu_rd_vld <= w_cpu_rd_vld_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_grant_wr) begin
          w_state_nxt = ST_WR;
        end else if (w_grant_rd) begin
          // An empty queue is answered directly without touching it.
          w_state_nxt = q_empty_i ? ST_RESP : ST_RD;
        end
      end
      ST_WR:      w_state_nxt = ST_WR_WAIT;
      ST_WR_WAIT: w_state_nxt = ST_IDLE;
      ST_RD:      w_state_nxt = ST_RD_WAIT;
      ST_RD_WAIT: w_state_nxt = ST_RESP;
      ST_RESP:    w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  // Output logic. Strobes are decoded from the next state so that they
  // come out of flops aligned with the state they belong to.
  always_comb begin
    w_q_write_nxt    = (w_state_nxt == ST_WR);
    w_q_read_nxt     = (w_state_nxt == ST_RD);
    w_cpu_rd_vld_nxt = (w_state_nxt == ST_RESP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_vld   <= 1'b0;
      r_hold_entry <= '0;
      r_hold_make  <= 1'b0;
    end else if (w_hold_load) begin
      r_hold_vld   <= 1'b1;
      r_hold_entry <= dec_entry_i;
      r_hold_make  <= dec_make_i;
    end else if (w_hold_release) begin
      r_hold_vld   <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_pend <= 1'b0;
    end else if (w_state_nxt == ST_RESP) begin
      r_rd_pend <= 1'b0;
    end else if (cpu_rd_req_i & ~w_rd_inflight) begin
      r_rd_pend <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_wr <= 1'b0;
    end else if (r_state == ST_WR_WAIT) begin
      r_last_wr <= 1'b1;
    end else if (r_state == ST_RD_WAIT) begin
      r_last_wr <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_data  <= '0;
      r_rd_empty <= 1'b0;
    end else if (r_state == ST_RD_WAIT) begin
      r_rd_data  <= q_entry_i;
      r_rd_empty <= 1'b0;
    end else if ((r_state == ST_IDLE) && (w_state_nxt == ST_RESP)) begin
      r_rd_data  <= '0;
      r_rd_empty <= 1'b1;
    end
  end

  // A clear wins over a drop in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf     <= 1'b0;
      r_ovf_cnt <= '0;
    end else if (cpu_ovf_clr_i) begin
      r_ovf     <= 1'b0;
      r_ovf_cnt <= '0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
      if (r_ovf_cnt != {CNT_W{1'b1}}) begin
        r_ovf_cnt <= r_ovf_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign cpu_rd_vld_o   = r_cpu_rd_vld;
  assign cpu_rd_data_o  = r_rd_data;
  assign cpu_rd_empty_o = r_rd_empty;
  assign ovf_o          = r_ovf;
  assign ovf_cnt_o      = r_ovf_cnt;
  assign pending_o      = r_hold_vld;
  assign q_write_o      = r_q_write;
  assign q_read_o       = r_q_read;
  assign q_entry_o      = r_hold_entry;
  assign q_make_o       = r_hold_make;

endmodule

// File: tb/tb_kb_queue_ctrl.sv
// Bench for kb_queue_ctrl: a 4-deep char_queue model sits on the queue
// side; CPU responses are checked against a scoreboard of expected reads.
module tb_kb_queue_ctrl;

  localparam int DW = 32;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          dec_vld_i;
  logic [17:0]   dec_entry_i;
  logic          dec_make_i;
  logic          cpu_rd_req_i;
  logic          cpu_ovf_clr_i;
  logic          cpu_rd_vld_o;
  logic [DW-1:0] cpu_rd_data_o;
  logic          cpu_rd_empty_o;
  logic          ovf_o;
  logic [CW-1:0] ovf_cnt_o;
  logic          pending_o;
  logic          q_write_o;
  logic          q_read_o;
  logic [17:0]   q_entry_o;
  logic          q_make_o;
  logic [DW-1:0] q_entry_i;
  logic          q_empty_i;
  logic          q_full_i;

  kb_queue_ctrl #(.DATA_WIDTH(DW), .CNT_W(CW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .dec_vld_i      (dec_vld_i),
    .dec_entry_i    (dec_entry_i),
    .dec_make_i     (dec_make_i),
    .cpu_rd_req_i   (cpu_rd_req_i),
    .cpu_ovf_clr_i  (cpu_ovf_clr_i),
    .cpu_rd_vld_o   (cpu_rd_vld_o),
    .cpu_rd_data_o  (cpu_rd_data_o),
    .cpu_rd_empty_o (cpu_rd_empty_o),
    .ovf_o          (ovf_o),
    .ovf_cnt_o      (ovf_cnt_o),
    .pending_o      (pending_o),
    .q_write_o      (q_write_o),
    .q_read_o       (q_read_o),
    .q_entry_o      (q_entry_o),
    .q_make_o       (q_make_o),
    .q_entry_i      (q_entry_i),
    .q_empty_i      (q_empty_i),
    .q_full_i       (q_full_i)
  );

  always #5 clk = ~clk;

  // char_queue model: write_i sampled, stored one cycle later; read_i pops
  // into a registered output.
  logic [18:0]   qm_mem [4];
  logic [2:0]    qm_cnt;
  logic [1:0]    qm_wp;
  logic [1:0]    qm_rp;
  logic          qm_wr_d;
  logic [DW-1:0] qm_out;
  logic          qm_push;
  logic          qm_pop;

  assign qm_push   = qm_wr_d && (qm_cnt != 3'd4);
  assign qm_pop    = q_read_o && (qm_cnt != 3'd0);
  assign q_full_i  = (qm_cnt == 3'd4);
  assign q_empty_i = (qm_cnt == 3'd0);
  assign q_entry_i = qm_out;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qm_cnt  <= 3'd0;
      qm_wp   <= 2'd0;
      qm_rp   <= 2'd0;
      qm_wr_d <= 1'b0;
      qm_out  <= '0;
    end else begin
      qm_wr_d <= q_write_o;
      if (qm_push) begin
        qm_mem[qm_wp] <= {q_make_o, q_entry_o};
        qm_wp         <= qm_wp + 2'd1;
      end
      if (qm_pop) begin
        qm_out <= {{(DW-19){1'b0}}, qm_mem[qm_rp]};
        qm_rp  <= qm_rp + 2'd1;
      end
      qm_cnt <= qm_cnt + {2'b00, qm_push} - {2'b00, qm_pop};
    end
  end

  typedef struct packed {
    logic [DW-1:0] data;
    logic          empty;
  } rsp_t;

  rsp_t exp_q[$];
  rsp_t mon_e;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_wr_pulses = 0;
  int   n_rd_pulses = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs === expv) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
  endtask

  task automatic push_exp(input logic [DW-1:0] d, input logic e);
    rsp_t r;
    r.data  = d;
    r.empty = e;
    exp_q.push_back(r);
  endtask

  function automatic logic [DW-1:0] exp_data(input logic [17:0] e, input logic m);
    return {{(DW-19){1'b0}}, m, e};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    dec_vld_i     = 1'b0;
    dec_entry_i   = '0;
    dec_make_i    = 1'b0;
    cpu_rd_req_i  = 1'b0;
    cpu_ovf_clr_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
  endtask

  // Response monitor / scoreboard.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("wr_rd_excl", 32'(q_write_o & q_read_o), 32'd0);
      if (q_write_o) n_wr_pulses++;
      if (q_read_o)  n_rd_pulses++;
      if (cpu_rd_vld_o) begin
        chk("sb_has_exp", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          chk("rd_data", cpu_rd_data_o, mon_e.data);
          chk("rd_empty", 32'(cpu_rd_empty_o), 32'(mon_e.empty));
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          base;
    int          ng;
    logic [5:0]  glog;
    logic [5:0]  gexp;
    logic        mk;

    do_reset();

    // Reset state
    chk("rst_rd_vld",  32'(cpu_rd_vld_o), 32'd0);
    chk("rst_rd_data", cpu_rd_data_o, 32'd0);
    chk("rst_ovf",     32'(ovf_o), 32'd0);
    chk("rst_ovf_cnt", 32'(ovf_cnt_o), 32'd0);
    chk("rst_pending", 32'(pending_o), 32'd0);
    chk("rst_q_write", 32'(q_write_o), 32'd0);
    chk("rst_q_read",  32'(q_read_o), 32'd0);

    // Empty read: response in cycle 2, queue untouched
    base = n_rd_pulses;
    push_exp('0, 1'b1);
    cpu_rd_req_i = 1'b1; tick(); cpu_rd_req_i = 1'b0;
    chk("erd_c1_vld", 32'(cpu_rd_vld_o), 32'd0);
    tick();
    chk("erd_c2_vld", 32'(cpu_rd_vld_o), 32'd1);
    tick();
    chk("erd_c3_vld", 32'(cpu_rd_vld_o), 32'd0);
    chk("erd_no_qread", 32'(n_rd_pulses - base), 32'd0);

    // Single push, then read it back
    dec_entry_i = 18'h00041; dec_make_i = 1'b1; dec_vld_i = 1'b1;
    tick(); dec_vld_i = 1'b0;
    chk("wr_c1_qwrite",  32'(q_write_o), 32'd0);
    chk("wr_c1_pending", 32'(pending_o), 32'd1);
    tick();
    chk("wr_c2_qwrite", 32'(q_write_o), 32'd1);
    chk("wr_c2_entry",  32'(q_entry_o), 32'h41);
    chk("wr_c2_make",   32'(q_make_o), 32'd1);
    tick();
    chk("wr_c3_qwrite", 32'(q_write_o), 32'd0);
    chk("wr_c3_entry",  32'(q_entry_o), 32'h41);
    tick();
    chk("wr_c4_pending", 32'(pending_o), 32'd0);

    push_exp(32'h00040041, 1'b0);
    cpu_rd_req_i = 1'b1; tick(); cpu_rd_req_i = 1'b0;
    chk("rd_c1_qread", 32'(q_read_o), 32'd0);
    tick();
    chk("rd_c2_qread", 32'(q_read_o), 32'd1);
    tick();
    chk("rd_c3_qread", 32'(q_read_o), 32'd0);
    chk("rd_c3_vld",   32'(cpu_rd_vld_o), 32'd0);
    tick();
    chk("rd_c4_vld",   32'(cpu_rd_vld_o), 32'd1);
    tick();

    // Filtered entry: no load, no overflow
    base = n_wr_pulses;
    dec_entry_i = 18'h3FFFF; dec_vld_i = 1'b1; tick(); dec_vld_i = 1'b0;
    chk("flt_pending", 32'(pending_o), 32'd0);
    chk("flt_ovf",     32'(ovf_o), 32'd0);
    repeat (4) tick();
    chk("flt_no_write", 32'(n_wr_pulses - base), 32'd0);

    // Fill the queue
    base = n_wr_pulses;
    for (int i = 0; i < 4; i++) begin
      dec_entry_i = 18'(32'h101 + i); dec_make_i = i[0]; dec_vld_i = 1'b1;
      tick(); dec_vld_i = 1'b0;
      repeat (4) tick();
    end
    chk("fill_writes", 32'(n_wr_pulses - base), 32'd4);
    dec_entry_i = 18'h105; dec_make_i = 1'b1; dec_vld_i = 1'b1;
    tick(); dec_vld_i = 1'b0;
    chk("fill_held_pending", 32'(pending_o), 32'd1);
    repeat (5) tick();
    chk("fill_held_still", 32'(pending_o), 32'd1);
    chk("fill_blocked", 32'(n_wr_pulses - base), 32'd4);
    dec_entry_i = 18'h3FFFF; dec_vld_i = 1'b1; tick(); dec_vld_i = 1'b0;
    chk("fill_flt_no_ovf", 32'(ovf_o), 32'd0);
    dec_entry_i = 18'h106; dec_vld_i = 1'b1; tick(); dec_vld_i = 1'b0;
    chk("ovf_flag", 32'(ovf_o), 32'd1);
    chk("ovf_cnt1", 32'(ovf_cnt_o), 32'd1);
    dec_entry_i = 18'h200; dec_vld_i = 1'b1;
    repeat (260) tick();
    dec_vld_i = 1'b0;
    chk("ovf_cnt_sat", 32'(ovf_cnt_o), 32'd255);

    // One read frees a slot; the held entry follows into the queue
    push_exp(exp_data(18'h101, 1'b0), 1'b0);
    cpu_rd_req_i = 1'b1; tick(); cpu_rd_req_i = 1'b0;
    for (int k = 0; k < 20 && pending_o; k++) tick();
    chk("fill_release_pending", 32'(pending_o), 32'd0);
    chk("fill_release_write", 32'(n_wr_pulses - base), 32'd5);
    tick();
    for (int i = 1; i < 5; i++) begin
      mk = (i == 4) ? 1'b1 : i[0];
      push_exp(exp_data(18'(32'h101 + i), mk), 1'b0);
      cpu_rd_req_i = 1'b1; tick(); cpu_rd_req_i = 1'b0;
      repeat (5) tick();
    end

    // Clear coincident with a drop
    dec_entry_i = 18'h300; dec_make_i = 1'b0; dec_vld_i = 1'b1; tick();
    dec_entry_i = 18'h301; cpu_ovf_clr_i = 1'b1; tick();
    dec_vld_i = 1'b0; cpu_ovf_clr_i = 1'b0;
    chk("clr_cnt", 32'(ovf_cnt_o), 32'd0);
    chk("clr_ovf", 32'(ovf_o), 32'd0);
    repeat (4) tick();
    push_exp(exp_data(18'h300, 1'b0), 1'b0);
    cpu_rd_req_i = 1'b1; tick(); cpu_rd_req_i = 1'b0;
    repeat (6) tick();

    // Contention: write wins first after reset, then grants alternate
    do_reset();
    for (int i = 0; i < 3; i++) push_exp(exp_data(18'h055, 1'b0), 1'b0);
    dec_entry_i = 18'h055; dec_make_i = 1'b0;
    ng   = 0;
    glog = '0;
    gexp = 6'b010101;
    for (int k = 0; k < 80 && ng < 6; k++) begin
      dec_vld_i = 1'b1; cpu_rd_req_i = 1'b1;
      tick();
      if (q_write_o) begin glog[ng] = 1'b1; ng++; end
      else if (q_read_o) begin glog[ng] = 1'b0; ng++; end
    end
    dec_vld_i = 1'b0; cpu_rd_req_i = 1'b0;
    chk("cont_ngrants", 32'(ng), 32'd6);
    for (int i = 0; i < 6; i++) chk($sformatf("cont_grant%0d", i), 32'(glog[i]), 32'(gexp[i]));
    repeat (8) tick();

    // Reset while a read sits in RD_WAIT
    base = n_rd_pulses;
    cpu_rd_req_i = 1'b1; dec_entry_i = 18'h077; dec_vld_i = 1'b1;
    tick(); cpu_rd_req_i = 1'b0; dec_vld_i = 1'b0;
    tick();
    chk("rrst_c2_qread", 32'(q_read_o), 32'd1);
    tick();
    chk("rrst_pre_pending", 32'(pending_o), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rrst_rd_vld",  32'(cpu_rd_vld_o), 32'd0);
    chk("rrst_rd_data", cpu_rd_data_o, 32'd0);
    chk("rrst_rd_empty", 32'(cpu_rd_empty_o), 32'd0);
    chk("rrst_ovf",     32'(ovf_o), 32'd0);
    chk("rrst_ovf_cnt", 32'(ovf_cnt_o), 32'd0);
    chk("rrst_pending", 32'(pending_o), 32'd0);
    chk("rrst_q_write", 32'(q_write_o), 32'd0);
    chk("rrst_q_read",  32'(q_read_o), 32'd0);
    chk("rrst_q_entry", 32'(q_entry_o), 32'd0);
    chk("rrst_q_make",  32'(q_make_o), 32'd0);
    repeat (2) begin
      @(posedge clk); #1;
      chk("rrst_hold_vld", 32'(cpu_rd_vld_o), 32'd0);
    end
    rst_n = 1'b1;
    base = n_wr_pulses;
    repeat (5) tick();
    chk("rrst_no_write", 32'(n_wr_pulses - base), 32'd0);
    chk("rrst_post_pending", 32'(pending_o), 32'd0);
    push_exp('0, 1'b1);
    cpu_rd_req_i = 1'b1; tick(); cpu_rd_req_i = 1'b0;
    tick();
    chk("rrst_erd_c2_vld", 32'(cpu_rd_vld_o), 32'd1);
    repeat (3) tick();

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
